// File: rtl/lc3b_mem_responder_pkg.sv
// lc3b_types: shared LC-3b word, write-mask and memory-responder state types
package lc3b_types;
    typedef logic [15:0] lc3b_word;
    typedef logic [1:0] lc3b_mem_wmask;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} lc3b_mem_state;
endpackage

// File: rtl/lc3b_mem_responder_mem_array.sv
// mem_array: word storage with a byte-masked synchronous write port and a registered read port
module mem_array
    import lc3b_types::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 we,
    input  lc3b_mem_wmask        wmask,
    input  logic [ADDR_BITS-1:0] waddr,
    input  lc3b_word             wdata,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] raddr,
    output lc3b_word             rdata
);
    lc3b_word mem [2**ADDR_BITS];
    // Byte lanes are written independently; contents are never reset.
    always_ff @(posedge clk) begin
        if (we && wmask[0]) mem[waddr][7:0] <= wdata[7:0];
        if (we && wmask[1]) mem[waddr][15:8] <= wdata[15:8];
    end
    // Read register holds the last read value and clears on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/lc3b_mem_responder.sv
// lc3b_mem_responder: answers LC-3b memory requests after LATENCY edges with a one-cycle mem_resp
module lc3b_mem_responder
    import lc3b_types::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  lc3b_word      mem_address,
    input  logic          mem_read,
    input  logic          mem_write,
    input  lc3b_mem_wmask mem_byte_enable,
    input  lc3b_word      mem_wdata,
    output lc3b_word      mem_rdata,
    output logic          mem_resp
);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY > 1 ? LATENCY - 2 : 0);
    localparam logic LAT_ONE = (LATENCY == 1);
    lc3b_mem_state        state;
    logic [3:0]           cnt;
    logic [ADDR_BITS-1:0] req_idx;
    logic                 req_read;
    logic                 req_write;
    lc3b_mem_wmask        req_be;
    lc3b_word             req_wdata;
    logic                 req;
    logic                 to_resp;
    logic                 rd_en;
    logic [ADDR_BITS-1:0] rd_idx;
    logic                 wr_en;
    // Read data is fetched on the edge entering RESP; a write commits on the edge leaving it.
    always_comb begin
        req     = mem_read | mem_write;
        to_resp = req && ((state == IDLE && LAT_ONE) || (state == BUSY && cnt == 4'd0));
        rd_en   = to_resp && (state == IDLE ? (mem_read && !mem_write) : (req_read && !req_write));
        rd_idx  = state == IDLE ? mem_address[ADDR_BITS:1] : req_idx;
        wr_en   = state == RESP && req_write;
    end
    // Request capture, latency countdown and the registered response pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_resp  <= 1'b0;
            req_idx   <= '0;
            req_read  <= 1'b0;
            req_write <= 1'b0;
            req_be    <= '0;
            req_wdata <= '0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    req_idx   <= mem_address[ADDR_BITS:1];
                    req_read  <= mem_read;
                    req_write <= mem_write;
                    req_be    <= mem_byte_enable;
                    req_wdata <= mem_wdata;
                    cnt       <= CNT_INIT;
                    state     <= LAT_ONE ? RESP : BUSY;
                    mem_resp  <= LAT_ONE;
                end
                BUSY: if (!req) begin
                    state <= IDLE;
                end else if (cnt == 4'd0) begin
                    state    <= RESP;
                    mem_resp <= 1'b1;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                RESP: begin
                    state    <= IDLE;
                    mem_resp <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
    mem_array #(.ADDR_BITS(ADDR_BITS)) u_array (
        .clk    (clk),
        .reset_n(reset_n),
        .we     (wr_en),
        .wmask  (req_be),
        .waddr  (req_idx),
        .wdata  (req_wdata),
        .re     (rd_en),
        .raddr  (rd_idx),
        .rdata  (mem_rdata)
    );
endmodule

// File: tb/tb_lc3b_mem_responder.sv
// tb_lc3b_mem_responder: scoreboard-driven checks of latency, byte masks, abort, aliasing and reset
module tb_lc3b_mem_responder;
    localparam int LAT = 4;
    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [15:0] mem_address = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [1:0]  mem_byte_enable = '0;
    logic [15:0] mem_wdata = '0;
    logic [15:0] mem_rdata;
    logic        mem_resp;
    int          errors = 0;
    int          checks = 0;
    logic [15:0] mdl [256];
    logic [15:0] exp_last = '0;
    logic [15:0] sb [$];

    always #5 clk = ~clk;

    lc3b_mem_responder #(.ADDR_BITS(8), .LATENCY(LAT)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .mem_address    (mem_address),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_byte_enable(mem_byte_enable),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_resp       (mem_resp)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start(input bit rd, input bit wr, input logic [15:0] a, input logic [1:0] m, input logic [15:0] d);
        mem_read = rd;
        mem_write = wr;
        mem_address = a;
        mem_byte_enable = m;
        mem_wdata = d;
        if (wr) begin
            if (m[0]) mdl[a[8:1]][7:0] = d[7:0];
            if (m[1]) mdl[a[8:1]][15:8] = d[15:8];
        end else begin
            exp_last = mdl[a[8:1]];
        end
        sb.push_back(exp_last);
    endtask

    task automatic wait_resp(input string name);
        int k;
        logic [15:0] e;
        k = 0;
        do begin
            tick();
            k++;
        end while (mem_resp !== 1'b1 && k < 20);
        checks++;
        if (mem_resp !== 1'b1 || k != LAT) begin
            errors++;
            $display("FAIL %s latency: resp=%b after %0d edges, expected 1 after %0d", name, mem_resp, k, LAT);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (mem_rdata !== e) begin
                errors++;
                $display("FAIL %s rdata: got %h expected %h", name, mem_rdata, e);
            end
        end
        mem_read = 1'b0;
        mem_write = 1'b0;
        tick();
        checks++;
        if (mem_resp !== 1'b0) begin
            errors++;
            $display("FAIL %s pulse width: resp=%b expected 0", name, mem_resp);
        end
    endtask

    task automatic test_reset;
        #1 reset_n = 1'b0;
        repeat (3) tick();
        checks++;
        if (mem_resp !== 1'b0 || mem_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL reset: resp=%b rdata=%h expected 0/0000", mem_resp, mem_rdata);
        end
        reset_n = 1'b1;
        repeat (5) begin
            tick();
            checks++;
            if (mem_resp !== 1'b0) begin
                errors++;
                $display("FAIL idle_no_req: resp=%b expected 0", mem_resp);
            end
        end
    endtask

    task automatic test_write_read;
        start(0, 1, 16'h0010, 2'b11, 16'hBEEF);
        wait_resp("wr_beef");
        start(1, 0, 16'h0010, 2'b00, 16'h0000);
        wait_resp("rd_beef");
    endtask

    task automatic test_byte_mask;
        start(0, 1, 16'h0020, 2'b11, 16'h1234);
        wait_resp("preload_20");
        start(0, 1, 16'h0020, 2'b01, 16'hABCD);
        wait_resp("wr_be01");
        start(1, 0, 16'h0020, 2'b00, 16'h0000);
        wait_resp("rd_12cd");
        start(0, 1, 16'h0020, 2'b10, 16'hABCD);
        wait_resp("wr_be10");
        start(1, 0, 16'h0020, 2'b00, 16'h0000);
        wait_resp("rd_abcd");
        start(0, 1, 16'h0020, 2'b00, 16'h0000);
        wait_resp("wr_be00");
        start(1, 0, 16'h0020, 2'b00, 16'h0000);
        wait_resp("rd_unchanged");
        start(1, 1, 16'h0020, 2'b11, 16'h5A5A);
        wait_resp("rw_priority");
        start(1, 0, 16'h0020, 2'b00, 16'h0000);
        wait_resp("rd_5a5a");
    endtask

    task automatic test_abort;
        start(0, 1, 16'h0030, 2'b11, 16'h1111);
        wait_resp("preload_30");
        mem_write = 1'b1;
        mem_address = 16'h0030;
        mem_byte_enable = 2'b11;
        mem_wdata = 16'h5555;
        tick();
        tick();
        mem_write = 1'b0;
        repeat (6) begin
            tick();
            checks++;
            if (mem_resp !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_resp: resp=%b expected 0", mem_resp);
            end
        end
        start(1, 0, 16'h0030, 2'b00, 16'h0000);
        wait_resp("rd_after_abort");
    endtask

    task automatic test_held_alias;
        int pulses;
        logic [15:0] e;
        start(1, 0, 16'h0210, 2'b00, 16'h0000);
        wait_resp("rd_alias_210");
        start(1, 0, 16'h0010, 2'b00, 16'h0000);
        sb.push_back(exp_last);
        sb.push_back(exp_last);
        pulses = 0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (mem_resp === 1'b1) begin
                pulses++;
                checks++;
                if (i != LAT + (pulses - 1) * (LAT + 1)) begin
                    errors++;
                    $display("FAIL held_spacing: pulse %0d at edge %0d expected %0d", pulses, i, LAT + (pulses - 1) * (LAT + 1));
                end
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    checks++;
                    if (mem_rdata !== e) begin
                        errors++;
                        $display("FAIL held_rdata: got %h expected %h", mem_rdata, e);
                    end
                end
            end
        end
        mem_read = 1'b0;
        checks++;
        if (pulses != 3) begin
            errors++;
            $display("FAIL held_pulses: got %0d expected 3", pulses);
        end
        sb.delete();
        repeat (LAT + 2) tick();
    endtask

    task automatic test_async_reset;
        logic [15:0] e;
        start(0, 1, 16'h0040, 2'b11, 16'h2222);
        wait_resp("preload_40");
        start(1, 0, 16'h0010, 2'b00, 16'h0000);
        wait_resp("rd_before_reset");
        mem_write = 1'b1;
        mem_address = 16'h0040;
        mem_byte_enable = 2'b11;
        mem_wdata = 16'h7777;
        tick();
        tick();
        #2 reset_n = 1'b0;
        mem_write = 1'b0;
        #1;
        checks++;
        if (mem_rdata !== 16'h0000 || mem_resp !== 1'b0) begin
            errors++;
            $display("FAIL busy_reset_clear: resp=%b rdata=%h expected 0/0000", mem_resp, mem_rdata);
        end
        tick();
        reset_n = 1'b1;
        exp_last = 16'h0000;
        start(1, 0, 16'h0040, 2'b00, 16'h0000);
        repeat (LAT) tick();
        e = sb.pop_front();
        checks++;
        if (mem_resp !== 1'b1 || mem_rdata !== e) begin
            errors++;
            $display("FAIL write_discarded: resp=%b rdata=%h expected 1/%h", mem_resp, mem_rdata, e);
        end
        #2 reset_n = 1'b0;
        mem_read = 1'b0;
        #1;
        checks++;
        if (mem_resp !== 1'b0 || mem_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL resp_async_drop: resp=%b rdata=%h expected 0/0000", mem_resp, mem_rdata);
        end
        tick();
        reset_n = 1'b1;
        exp_last = 16'h0000;
        start(1, 0, 16'h0040, 2'b00, 16'h0000);
        wait_resp("rd_after_reset");
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mdl[i] = 16'h0000;
        test_reset();
        test_write_read();
        test_byte_mask();
        test_abort();
        test_held_alias();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
